// File: rtl/key_debounce_scan.sv
// key_debounce_scan
// Conditions raw keyboard contacts into the clean KEYBOARD bus:
//   2-flop synchroniser -> per-key debounce counter -> stable state,
//   one-cycle press/release events, and a registered lowest-held-key encoder.
// Build option: define KEY_AUTOREPEAT_EN to add an auto-repeat timer that
// follows the lowest held key; without it key_repeat is tied low.
module key_debounce_scan #(
    parameter int NKEYS        = 13,
    parameter int DB_CYCLES    = 250000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] key_raw,
    output logic [NKEYS-1:0] key_stable,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic             any_key,
    output logic [3:0]       low_key_idx,
    output logic             low_key_valid,
    output logic             key_repeat
);

    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    // Reject configurations the counters cannot represent.
    if (NKEYS < 1 || NKEYS > 16 || DB_CYCLES < 2 ||
        REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("key_debounce_scan: parameter out of range");
    end

    logic [NKEYS-1:0] sync1_q;
    logic [NKEYS-1:0] sync2_q;
    logic [CW-1:0]    db_cnt_q [NKEYS];
    logic [CW-1:0]    db_cnt_d [NKEYS];
    logic [NKEYS-1:0] stable_q;
    logic [NKEYS-1:0] stable_d;
    logic [NKEYS-1:0] press_q;
    logic [NKEYS-1:0] release_q;
    logic             any_key_q;
    logic [3:0]       low_idx_q;
    logic             low_valid_q;
    logic [3:0]       enc_idx;
    logic             enc_valid;

    // Two-stage synchroniser for the asynchronous contacts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    // Per-key debounce: count consecutive disagreeing cycles, flip on the last one.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NKEYS; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Debounce state and edge events; events share the edge that flips the stable bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NKEYS; i++) begin
                db_cnt_q[i] <= '0;
            end
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            stable_q  <= stable_d;
            press_q   <= stable_d & ~stable_q;
            release_q <= ~stable_d & stable_q;
        end
    end

    // Lowest-index priority encoder over the debounced state.
    always_comb begin
        enc_idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (stable_q[i]) begin
                enc_idx = 4'(i);
            end
        end
    end

    assign enc_valid = |stable_q;

    // Encoder outputs are registered, so they trail key_stable by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            any_key_q   <= 1'b0;
            low_idx_q   <= '0;
            low_valid_q <= 1'b0;
        end else begin
            any_key_q   <= enc_valid;
            low_idx_q   <= enc_idx;
            low_valid_q <= enc_valid;
        end
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int            RMAX      = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            TW        = $clog2(RMAX + 1);
    localparam logic [TW-1:0] RPT_FIRST = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RPT_NEXT  = TW'(REPEAT_RATE - 1);

    logic [TW-1:0] rpt_tmr_q;
    logic [TW-1:0] rpt_tmr_d;
    logic          rpt_q;
    logic          rpt_d;
    logic          rpt_restart;

    // Restart on the same edge that low_key_valid rises or low_key_idx changes,
    // so the first pulse lands exactly REPEAT_DELAY cycles after that update.
    assign rpt_restart = enc_valid && (!low_valid_q || (enc_idx != low_idx_q));

    // Down-counting repeat timer; terminal count emits a pulse and reloads the rate.
    always_comb begin
        rpt_tmr_d = rpt_tmr_q;
        rpt_d     = 1'b0;
        if (!enc_valid) begin
            rpt_tmr_d = '0;
        end else if (rpt_restart) begin
            rpt_tmr_d = RPT_FIRST;
        end else if (rpt_tmr_q == '0) begin
            rpt_d     = 1'b1;
            rpt_tmr_d = RPT_NEXT;
        end else begin
            rpt_tmr_d = rpt_tmr_q - TW'(1);
        end
    end

    // Repeat timer and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_tmr_q <= '0;
            rpt_q     <= 1'b0;
        end else begin
            rpt_tmr_q <= rpt_tmr_d;
            rpt_q     <= rpt_d;
        end
    end

    assign key_repeat = rpt_q;
`else
    assign key_repeat = 1'b0;
`endif

    assign key_stable    = stable_q;
    assign key_press     = press_q;
    assign key_release   = release_q;
    assign any_key       = any_key_q;
    assign low_key_idx   = low_idx_q;
    assign low_key_valid = low_valid_q;

endmodule
